// File: rtl/fb_ram_pkg.sv
// Shared types for the framebuffer RAM: clear-engine state encoding.
package fb_ram_pkg;

    localparam logic [1:0] ClrIdleEnc  = 2'b00;
    localparam logic [1:0] ClrClearEnc = 2'b01;
    localparam logic [1:0] ClrDoneEnc  = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = ClrIdleEnc,
        StClear = ClrClearEnc,
        StDone  = ClrDoneEnc
    } clr_state_e;

endpackage

// File: rtl/fb_ram_if.sv
// Framebuffer RAM bus: write port, read port and clear-engine control/status.
interface fb_ram_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  clr_start;
    logic [DATA_WIDTH-1:0] clr_value;
    logic                  clr_busy;
    logic                  clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_start, clr_value,
        input  rd_data, rd_valid, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_start, clr_value,
        output rd_data, rd_valid, clr_busy, clr_done
    );
endinterface

// File: rtl/fb_ram_clear_fsm.sv
// Clear engine: sweeps every address once, writing a latched fill value.
module fb_ram_clear_fsm
    import fb_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DATA_WIDTH-1:0] clr_data
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    val_d   = clr_value;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                // Hold on the last address rather than wrapping to 0.
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign clr_busy = (state_q == StClear);
    assign clr_done = (state_q == StDone);
    assign clr_we   = clr_busy;
    assign clr_addr = cnt_q;
    assign clr_data = val_q;

endmodule

// File: rtl/fb_ram.sv
// Simple-dual-port framebuffer RAM with registered read and built-in clear engine.
// Define FB_RAM_BYPASS_EN for write-first same-address forwarding (default read-first).
module fb_ram
    import fb_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    fb_ram_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_busy, clr_done, clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_data;

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q;

    fb_ram_clear_fsm #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_start(bus.clr_start),
        .clr_value(bus.clr_value),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    // Clear owns the write port; user writes during a sweep are dropped.
    always_comb begin
        we    = clr_we | (bus.wr_en & ~clr_busy);
        waddr = clr_we ? clr_addr : bus.wr_addr;
        wdata = clr_we ? clr_data : bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_data_d = mem[bus.rd_addr];
`ifdef FB_RAM_BYPASS_EN
        if (we && (waddr == bus.rd_addr)) begin
            rd_data_d = wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

endmodule

// File: doc/fb_ram.md
# fb_ram

Parametrised simple-dual-port synchronous RAM for the VGA framebuffer path: one write port, one independent read port, registered read data with a valid strobe, and a built-in clear engine that fills the whole array with a constant. It sits between the pixel-drawing logic (write side) and the VGA scan-out logic (read side), all in the single pixel clock domain.

## Interface
- ADDR_WIDTH, 10, address bits; DEPTH = 1 << ADDR_WIDTH words
- DATA_WIDTH, 4, bits per word (pixel)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request this cycle
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request this cycle
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data updated this cycle (one cycle after rd_en)
- clr_start  in  1  start a full-array clear (pulse)
- clr_value  in  DATA_WIDTH  fill value, sampled on accepted clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write

## Operation
- Reset values: rd_data = 0, rd_valid = 0, clr_busy = 0, clr_done = 0, clear counter = 0, FSM = IDLE. Array contents are not reset.
- Write: wr_en high in IDLE/DONE -> mem[wr_addr] <= wr_data at that edge.
- Read: rd_en high -> rd_data <= mem[rd_addr], rd_valid = 1 next cycle. rd_en low -> rd_data holds, rd_valid = 0.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_start = 1 -> latch clr_value, counter = 0, go CLEAR.
  - CLEAR: each cycle mem[counter] <= latched value, counter++; at counter = DEPTH-1 write it and go DONE. clr_busy = 1 throughout CLEAR.
  - DONE: clr_done = 1 for this one cycle, go IDLE.
- clr_start while CLEAR or DONE is ignored (no restart, no queueing).
- User writes during CLEAR are dropped silently; clear has priority. Writes in DONE are accepted.
- Reads are always served, including during CLEAR; they return current array contents (mix of old and cleared words).
- Counter is ADDR_WIDTH bits; terminal detection is counter == DEPTH-1, no wrap to 0 inside CLEAR.
- rst_n low mid-clear: FSM -> IDLE, counter -> 0, clr_busy -> 0 immediately; already-written words stay cleared, rest unchanged.

## Timing
- Read latency 1 cycle: rd_en at edge N -> rd_data/rd_valid valid after edge N+1's register update, i.e. during cycle N+1.
- Write visible to a read issued the next cycle or later.
- clr_start sampled at edge N -> clr_busy high from cycle N+1 for exactly DEPTH cycles -> clr_done high in cycle N+1+DEPTH -> IDLE in N+2+DEPTH.
- Same-cycle read and write (user or clear) to the same address: see Configuration.
- Throughput: one read and one write per cycle, no stalls.

## Configuration
- FB_RAM_BYPASS_EN defined: same-cycle write (user or clear) and read to the same address forward the write data; rd_data = new value (write-first).
- Undefined: rd_data returns the pre-write contents (read-first); new value visible from the next read.

## Structure
- Package fb_ram_pkg: clear-FSM state typedef (IDLE, CLEAR, DONE) and state-encoding constants.
- One sub-module: fb_ram_clear_fsm (state, counter, latched value, clr_busy/clr_done, outputs clear write enable/address/data); fb_ram owns the array, write mux and read register.

## Test plan
- Reset then write 0xA to addr 5, read addr 5 next cycle -> rd_data = 0xA with rd_valid high exactly one cycle after rd_en.
- Same-cycle write 0x3 and read at addr 7 holding 0xC -> rd_data = 0xC without FB_RAM_BYPASS_EN, 0x3 with it.
- clr_start with clr_value = 0x6 (DEPTH = 1024) -> clr_busy high 1024 cycles, clr_done single pulse, reads of addr 0, 511, 1023 afterwards return 0x6.
- wr_en to addr 100 with 0xF during CLEAR, and second clr_start mid-clear -> write dropped (addr 100 reads clr_value), clear finishes on original schedule.
- rst_n asserted at clear cycle 200 -> outputs return to reset values asynchronously; addr 0-199 hold clr_value, addr 300 holds prior data.
- Back-to-back reads of addr 0..15 every cycle -> 16 consecutive rd_valid cycles, data in order, no bubbles.
